// File: rtl/snake_pkg.sv
// Shared Snake-game definitions: draw scheduler states and screen/block geometry.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int BLOCK_PIX = 16;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

endpackage

// File: rtl/draw_sched_arb.sv
// Combinational requester arbiter: fixed priority (lowest index wins), or
// round-robin starting after last_winner when DRAW_SCHED_RR_EN is defined.
module draw_sched_arb #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;

  assign any_req = |req;

`ifdef DRAW_SCHED_RR_EN
  // Walk offsets from farthest to nearest so the requester right after
  // last_winner is the final (winning) assignment.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_winner) + k) % N_REQ);
      if (req[cand]) begin
        grant_idx = cand;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_winner;

  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req[cand]) begin
        grant_idx = cand;
      end
    end
  end
`endif

  assign grant = any_req ? (N_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/draw_sched.sv
// Snake block-draw scheduler: arbitrates requesters, drives 16 datapath go
// cycles per 4x4 block, plot one cycle behind. Optional DRAW_SCHED_RR_EN.
module draw_sched
  import snake_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int COLOUR_W  = 3,
  parameter int BLOCK_PIX = snake_pkg::BLOCK_PIX
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [X_W*N_REQ-1:0]      req_x,
  input  logic [Y_W*N_REQ-1:0]      req_y,
  input  logic [COLOUR_W*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]          done,
  output logic                      busy,
  output logic                      dp_go,
  output logic [X_W-1:0]            dp_x_in,
  output logic [Y_W-1:0]            dp_y_in,
  output logic [COLOUR_W-1:0]       colour,
  output logic                      plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]      winner_q, winner_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  plot_q, plot_d;

  logic [X_W-1:0]        slice_x      [N_REQ];
  logic [Y_W-1:0]        slice_y      [N_REQ];
  logic [COLOUR_W-1:0]   slice_colour [N_REQ];

  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_req;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice_x[gi]      = req_x[X_W*gi +: X_W];
    assign slice_y[gi]      = req_y[Y_W*gi +: Y_W];
    assign slice_colour[gi] = req_colour[COLOUR_W*gi +: COLOUR_W];
  end

  draw_sched_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req),
    .last_winner (last_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .any_req     (any_req)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    last_d   = last_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    // plot tracks the datapath's registered x/y, one cycle behind dp_go
    plot_d   = (state_q == DRAW);

    case (state_q)
      IDLE: begin
        if (any_req) begin
          winner_d = grant;
          last_d   = grant_idx;
          x_d      = slice_x[grant_idx];
          y_d      = slice_y[grant_idx];
          colour_d = slice_colour[grant_idx];
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (cnt_q == CNT_W'(BLOCK_PIX - 1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      winner_q <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign dp_go   = (state_q == DRAW);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) ? winner_q : '0;
  assign dp_x_in = x_q;
  assign dp_y_in = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;

endmodule

// File: doc/draw_sched.md
Name: draw_sched

Overview:
- Sequences and shares the 4x4-block pixel datapath among several drawing requesters in the Snake game, e.g. tail erase, head draw and food draw.
- Arbitrates one request at a time and latches its block origin and colour.
- Issues exactly 16 datapath `go` cycles per block.
- Generates the VGA adapter's `plot` strobe aligned to the datapath's registered x/y, then acknowledges the requester.

Parameters:
- N_REQ, 3, number of requesters; index 0 is highest priority in fixed mode.
- COLOUR_W, 3, colour width passed to the VGA adapter.
- BLOCK_PIX, 16, pixels per block; must equal the datapath counter span of 4x4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester draw request; level, held until its done pulse
- req_x  in  8*N_REQ  packed block-origin x; requester i uses bits [8i+7:8i]
- req_y  in  7*N_REQ  packed block-origin y
- req_colour  in  COLOUR_W*N_REQ  packed colour
- done  out  N_REQ  one-cycle pulse to the served requester
- busy  out  1  high in any state other than IDLE
- dp_go  out  1  datapath advance enable
- dp_x_in  out  8  latched origin x to datapath
- dp_y_in  out  7  latched origin y to datapath
- colour  out  COLOUR_W  latched colour to VGA adapter
- plot  out  1  VGA write enable

Behaviour:
- Reset and clock: reset reset_n, synchronous, active-low; clock clk. The datapath shares the same reset, so both counters restart at 0 together.
- Reset values: state=IDLE; cnt=0; done=0; busy=0; dp_go=0; plot=0; dp_x_in=0; dp_y_in=0; colour=0; winner=0.
- IDLE: if any req bit is set, select a winner and register winner, dp_x_in, dp_y_in and colour from that slice, then go to DRAW. Otherwise stay in IDLE.
- Arbitration: fixed priority; the lowest index wins.
- DRAW: dp_go=1 every cycle; cnt increments. When cnt==BLOCK_PIX-1, cnt returns to 0 and the state goes to FLUSH. Exactly BLOCK_PIX go cycles per grant.
- FLUSH: one cycle with dp_go=0 so the last pixel's plot is emitted; go to DONE.
- DONE: done[winner]=1 for one cycle; go to IDLE.
- plot is a register: plot <= (state==DRAW). It lags dp_go by one cycle to match the datapath's registered x/y, so it is high for exactly BLOCK_PIX cycles.
- Latency: req first sampled high at edge t gives:
  - dp_go high for cycles t+1..t+16;
  - plot high for t+2..t+17;
  - done pulse at t+18;
  - next grant earliest at edge t+19.
- Request drop: req deasserting during DRAW/FLUSH/DONE is ignored; the block completes and done still pulses.
- Request changes: changes to req_x/req_y/req_colour after the grant are ignored; values are latched once.
- Simultaneous requests: served one at a time by priority. A requester whose req is still high in IDLE after its own done is served again; requesters must drop req on done.
- No clipping: requesters must keep x≤156 and y≤116. Arithmetic wraps at the datapath width.
- Reset mid-operation: returns to IDLE within one edge. No done is issued for the aborted block, and plot is 0 on the following cycle.

Optional Feature:
- Macro DRAW_SCHED_RR_EN.
- Defined: round-robin arbitration. The search starts at (last_winner+1) mod N_REQ; last_winner resets to N_REQ-1, so the first search starts at 0.
- Undefined: fixed priority as above.
- All timing is identical in both modes.

Decomposition:
- Shared package snake_pkg holds:
  - state enum {IDLE, DRAW, FLUSH, DONE};
  - constants X_W=8, Y_W=7, BLOCK_PIX=16, SCREEN_W=160, SCREEN_H=120.
- One natural sub-module: draw_sched_arb. It is combinational: req plus last_winner in, one-hot grant and encoded index out, and it contains the RR_EN variant.
- FSM, counter and latches stay in draw_sched.

Test Plan:
- Single request: req=3'b010, x1=20, y1=40, colour1=3'b100 -> dp_x_in=20, dp_y_in=40; dp_go high 16 cycles; plot high 16 cycles starting one cycle after dp_go; done=3'b010 at t+18; busy low after.
- Datapath coupling: same stimulus with the datapath instantiated -> plotted (x,y) covers all 16 pixels of 20..23 × 40..43 exactly once, and the datapath row/col counters are back to 0.
- Contention: req=3'b111 held, each bit dropped on its done -> fixed mode serves 0,1,2. With DRAW_SCHED_RR_EN after a prior winner of 1, order is 2,0,1. No idle gap beyond the 1 IDLE cycle.
- Mid-grant drop: req0 drops at t+5 and req_x0 changes to 99 at t+6 -> the block still completes at the original x; done[0] pulses at t+18.
- Reset mid-draw: reset_n low at t+8 for 1 cycle -> next cycle all outputs are at reset values, no done; a fresh request afterwards draws a correct 16-pixel block.
- Back-to-back: req2 held continuously -> grants at t and t+19; plot is low during FLUSH-to-DONE-to-IDLE and never exceeds 16 pulses per grant.
